// File: rtl/conv3x3_relu.sv
// 3x3 zero-padded convolution with bias, ReLU and 4-bit saturation; one output pixel per clock.
// Optional macro CONV_SAT_COUNT_EN enables the saturated-pixel counter on sat_count.
module conv3x3_relu #(
   parameter int SIZE    = 64,
   parameter int SHIFT   = 0,
   parameter int IN_BITS = SIZE*SIZE*4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [IN_BITS-1:0] input_matrix,
   input  logic [35:0]        kernel,
   input  logic [7:0]         bias,
   output logic [IN_BITS-1:0] output_matrix,
   output logic               busy,
   output logic               done,
   output logic [15:0]        sat_count
);

   localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      row, col;
   logic [35:0]        kernel_q;
   logic signed [7:0]  bias_q;
   logic               load, last_px;
   logic signed [12:0] acc, shifted;
   logic [3:0]         px_out;
   logic               px_sat;

   assign last_px = (row == CW'(SIZE-1)) && (col == CW'(SIZE-1));

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_px) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (!start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Neighbourhood MAC; taps falling outside the map read as zero.
   always_comb begin : conv_b
      int                 nr, nc;
      logic [3:0]         pix;
      logic signed [3:0]  w;
      logic signed [12:0] prod;
      acc  = {{5{bias_q[7]}}, bias_q};
      nr   = 0;
      nc   = 0;
      pix  = '0;
      w    = '0;
      prod = '0;
      for (int kr = 0; kr < 3; kr++) begin
         for (int kc = 0; kc < 3; kc++) begin
            nr = int'(row) + kr - 1;
            nc = int'(col) + kc - 1;
            if (nr >= 0 && nr < SIZE && nc >= 0 && nc < SIZE)
               pix = input_matrix[(nr*SIZE + nc)*4 +: 4];
            else
               pix = '0;
            w    = kernel_q[(kr*3 + kc)*4 +: 4];
            prod = 13'($signed({1'b0, pix})) * 13'(w);
            acc  = acc + prod;
         end
      end
   end

   assign shifted = acc >>> SHIFT;
   assign px_sat  = !shifted[12] && (shifted > 13'sd15);
   assign px_out  = shifted[12] ? 4'd0 : (px_sat ? 4'd15 : shifted[3:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         row           <= '0;
         col           <= '0;
         kernel_q      <= '0;
         bias_q        <= '0;
         output_matrix <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            kernel_q <= kernel;
            bias_q   <= bias;
            row      <= '0;
            col      <= '0;
         end else if (state == RUN) begin
            output_matrix[(int'(row)*SIZE + int'(col))*4 +: 4] <= px_out;
            if (col == CW'(SIZE-1)) begin
               col <= '0;
               row <= row + CW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end

`ifdef CONV_SAT_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sat_count <= '0;
      else if (load)
         sat_count <= '0;
      else if (state == RUN && px_sat && sat_count != 16'hFFFF)
         sat_count <= sat_count + 16'd1;
   end
`else
   assign sat_count = '0;
`endif

endmodule
